phase1_pair_scheduler: RTL and testbench

Phase-1 work generator, sits directly upstream of the timestep phase controller. While phase 1 is open, it walks every home cell and its 14 half-shell neighbour cells and issues (home, neighbour) cell-pair requests to the force pipeline over a valid/ready handshake. It waits for the pipeline to drain, then pulses phase-1 completion back to the controller. It also owns the timestep counter that the controller compares against.

---
 rtl/phase1_pair_scheduler.sv | 276 +++++++++++++++++++++++++++
 tb/tb_phase1_pair_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase1_pair_scheduler.sv
// Phase-1 pair scheduler: issues (home, half-shell neighbour) cell pairs, drains the force pipe, signals done.
// Optional `PHASE1_SCHED_PERF_EN adds the per-step stall_cycles counter output.
module phase1_pair_scheduler #(
   parameter int N_CELL_X     = 3,
   parameter int N_CELL_Y     = 3,
   parameter int N_CELL_Z     = 3,
   parameter int CELL_W       = 6,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              phase1_ready,
   input  logic              double_buffer,
   input  logic              pair_ready,
   input  logic              pipe_empty,
   output logic              pair_valid,
   output logic [CELL_W-1:0] home_cell,
   output logic [CELL_W-1:0] nbr_cell,
   output logic              read_bank,
   output logic              phase1_done,
   output logic [31:0]       step
`ifdef PHASE1_SCHED_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int NCELLS = N_CELL_X * N_CELL_Y * N_CELL_Z;
   localparam int DW     = $clog2(DRAIN_CYCLES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0]        K_FIRST   = 5'd13;
   localparam logic [4:0]        K_LAST    = 5'd26;
   localparam logic [CELL_W-1:0] ZERO      = {CELL_W{1'b0}};
   localparam logic [CELL_W-1:0] ONE       = CELL_W'(1);
   localparam logic [CELL_W-1:0] NX        = CELL_W'(N_CELL_X);
   localparam logic [CELL_W-1:0] NY        = CELL_W'(N_CELL_Y);
   localparam logic [CELL_W-1:0] NX_M1     = CELL_W'(N_CELL_X - 1);
   localparam logic [CELL_W-1:0] NY_M1     = CELL_W'(N_CELL_Y - 1);
   localparam logic [CELL_W-1:0] NZ_M1     = CELL_W'(N_CELL_Z - 1);
   localparam logic [CELL_W-1:0] LAST_HOME = CELL_W'(NCELLS - 1);
   localparam logic [DW-1:0]     DRAIN_MAX = DW'(DRAIN_CYCLES);
   localparam logic [DW-1:0]     DRAIN_ONE = DW'(1);

   // Per-axis digit: 0 means -1, 1 means 0, 2 means +1.
   function automatic logic [CELL_W-1:0] wrap_axis(input logic [CELL_W-1:0] c,
                                                   input logic [1:0]        d,
                                                   input logic [CELL_W-1:0] lim_m1);
      logic [CELL_W-1:0] r;
      case (d)
         2'd0:    r = (c == ZERO) ? lim_m1 : c - ONE;
         2'd2:    r = (c == lim_m1) ? ZERO : c + ONE;
         default: r = c;
      endcase
      return r;
   endfunction

   // Offset code k = 9*dz' + 3*dy' + dx', returned as {dz', dy', dx'}.
   function automatic logic [5:0] offset_digits(input logic [4:0] k);
      logic [5:0] d;
      case (k)
         5'd14:   d = {2'd1, 2'd1, 2'd2};
         5'd15:   d = {2'd1, 2'd2, 2'd0};
         5'd16:   d = {2'd1, 2'd2, 2'd1};
         5'd17:   d = {2'd1, 2'd2, 2'd2};
         5'd18:   d = {2'd2, 2'd0, 2'd0};
         5'd19:   d = {2'd2, 2'd0, 2'd1};
         5'd20:   d = {2'd2, 2'd0, 2'd2};
         5'd21:   d = {2'd2, 2'd1, 2'd0};
         5'd22:   d = {2'd2, 2'd1, 2'd1};
         5'd23:   d = {2'd2, 2'd1, 2'd2};
         5'd24:   d = {2'd2, 2'd2, 2'd0};
         5'd25:   d = {2'd2, 2'd2, 2'd1};
         5'd26:   d = {2'd2, 2'd2, 2'd2};
         default: d = {2'd1, 2'd1, 2'd1};
      endcase
      return d;
   endfunction

   function automatic logic [CELL_W-1:0] nbr_index(input logic [CELL_W-1:0] x,
                                                   input logic [CELL_W-1:0] y,
                                                   input logic [CELL_W-1:0] z,
                                                   input logic [4:0]        k);
      logic [5:0]        d;
      logic [CELL_W-1:0] nx, ny, nz;
      d  = offset_digits(k);
      nx = wrap_axis(x, d[1:0], NX_M1);
      ny = wrap_axis(y, d[3:2], NY_M1);
      nz = wrap_axis(z, d[5:4], NZ_M1);
      return nx + NX * (ny + NY * nz);
   endfunction

   logic [1:0]        state_q, state_d;
   logic [CELL_W-1:0] hx_q, hy_q, hz_q, hx_d, hy_d, hz_d, hx_n, hy_n, hz_n;
   logic [CELL_W-1:0] home_q, home_d, home_n;
   logic [4:0]        k_q, k_d, k_n;
   logic [DW-1:0]     drain_q, drain_d;
   logic              valid_q, valid_d;
   logic [CELL_W-1:0] nbr_q, nbr_d;
   logic              bank_q, bank_d;
   logic              done_q, done_d;
   logic [31:0]       step_q, step_d;
   logic              last_pair_s;
`ifdef PHASE1_SCHED_PERF_EN
   logic [31:0]       stall_q, stall_d;
`endif

   assign last_pair_s = (home_q == LAST_HOME) && (k_q == K_LAST);

   // Position of the pair that follows the current one (k inner, x/y/z outer).
   always_comb begin
      hx_n   = hx_q;
      hy_n   = hy_q;
      hz_n   = hz_q;
      home_n = home_q;
      k_n    = k_q;
      if (k_q == K_LAST) begin
         k_n    = K_FIRST;
         home_n = home_q + ONE;
         if (hx_q == NX_M1) begin
            hx_n = ZERO;
            if (hy_q == NY_M1) begin
               hy_n = ZERO;
               hz_n = (hz_q == NZ_M1) ? ZERO : hz_q + ONE;
            end else begin
               hy_n = hy_q + ONE;
            end
         end else begin
            hx_n = hx_q + ONE;
         end
      end else begin
         k_n = k_q + 5'd1;
      end
   end

   // Sequencer next-state and registered-output next values.
   always_comb begin
      state_d = state_q;
      hx_d    = hx_q;
      hy_d    = hy_q;
      hz_d    = hz_q;
      home_d  = home_q;
      k_d     = k_q;
      drain_d = drain_q;
      valid_d = valid_q;
      nbr_d   = nbr_q;
      bank_d  = bank_q;
      done_d  = done_q;
      step_d  = step_q;
`ifdef PHASE1_SCHED_PERF_EN
      stall_d = stall_q;
`endif
      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (phase1_ready) begin
               state_d = S_ISSUE;
               bank_d  = double_buffer;
               hx_d    = ZERO;
               hy_d    = ZERO;
               hz_d    = ZERO;
               home_d  = ZERO;
               k_d     = K_FIRST;
               valid_d = 1'b1;
               nbr_d   = nbr_index(ZERO, ZERO, ZERO, K_FIRST);
`ifdef PHASE1_SCHED_PERF_EN
               stall_d = 32'd0;
`endif
            end else begin
               valid_d = 1'b0;
            end
         end
         S_ISSUE: begin
            if (pair_ready) begin
               if (last_pair_s) begin
                  state_d = S_DRAIN;
                  valid_d = 1'b0;
                  drain_d = {DW{1'b0}};
                  hx_d    = ZERO;
                  hy_d    = ZERO;
                  hz_d    = ZERO;
                  home_d  = ZERO;
                  k_d     = K_FIRST;
                  nbr_d   = ZERO;
               end else begin
                  hx_d   = hx_n;
                  hy_d   = hy_n;
                  hz_d   = hz_n;
                  home_d = home_n;
                  k_d    = k_n;
                  nbr_d  = nbr_index(hx_n, hy_n, hz_n, k_n);
               end
            end else begin
`ifdef PHASE1_SCHED_PERF_EN
               stall_d = (stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1;
`endif
               valid_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_MAX) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               step_d  = step_q + 32'd1;
            end else begin
               drain_d = pipe_empty ? drain_q + DRAIN_ONE : {DW{1'b0}};
            end
         end
         S_DONE: begin
            if (!phase1_ready) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end else begin
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any partial step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         hx_q    <= ZERO;
         hy_q    <= ZERO;
         hz_q    <= ZERO;
         home_q  <= ZERO;
         k_q     <= K_FIRST;
         drain_q <= {DW{1'b0}};
         valid_q <= 1'b0;
         nbr_q   <= ZERO;
         bank_q  <= 1'b0;
         done_q  <= 1'b0;
         step_q  <= 32'd0;
`ifdef PHASE1_SCHED_PERF_EN
         stall_q <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         hx_q    <= hx_d;
         hy_q    <= hy_d;
         hz_q    <= hz_d;
         home_q  <= home_d;
         k_q     <= k_d;
         drain_q <= drain_d;
         valid_q <= valid_d;
         nbr_q   <= nbr_d;
         bank_q  <= bank_d;
         done_q  <= done_d;
         step_q  <= step_d;
`ifdef PHASE1_SCHED_PERF_EN
         stall_q <= stall_d;
`endif
      end
   end

   assign pair_valid  = valid_q;
   assign home_cell   = home_q;
   assign nbr_cell    = nbr_q;
   assign read_bank   = bank_q;
   assign phase1_done = done_q;
   assign step        = step_q;
`ifdef PHASE1_SCHED_PERF_EN
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_phase1_pair_scheduler.sv
// Bench for phase1_pair_scheduler: randomized handshake stimulus against a coordinate-arithmetic pair model.
module tb_phase1_pair_scheduler;
   localparam int NX = 3;
   localparam int NY = 3;
   localparam int NZ = 3;
   localparam int NC = NX * NY * NZ;
   localparam int NP = NC * 14;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset, phase1_ready, double_buffer, pair_ready, pipe_empty;
   logic          pair_valid, read_bank, phase1_done;
   logic [CW-1:0] home_cell, nbr_cell;
   logic [31:0]   step;
`ifdef PHASE1_SCHED_PERF_EN
   logic [31:0]   stall_cycles;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int exp_h[NP];
   int exp_n[NP];
   int acc_h[$];
   int acc_n[$];
   int unstable, bank_bad, valid_cycles, done_lat, stall_seen;

   always #5 clk = ~clk;

   phase1_pair_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .phase1_ready  (phase1_ready),
      .double_buffer (double_buffer),
      .pair_ready    (pair_ready),
      .pipe_empty    (pipe_empty),
      .pair_valid    (pair_valid),
      .home_cell     (home_cell),
      .nbr_cell      (nbr_cell),
      .read_bank     (read_bank),
      .phase1_done   (phase1_done),
      .step          (step)
`ifdef PHASE1_SCHED_PERF_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   // Reference list: every home cell, then k = 13..26, neighbour by per-axis modulo.
   function automatic void build_model();
      int p = 0;
      for (int h = 0; h < NC; h++) begin
         int x = h % NX;
         int y = (h / NX) % NY;
         int z = h / (NX * NY);
         for (int k = 13; k <= 26; k++) begin
            int dx = k % 3 - 1;
            int dy = (k / 3) % 3 - 1;
            int dz = k / 9 - 1;
            exp_h[p] = h;
            exp_n[p] = (x + dx + NX) % NX + NX * ((y + dy + NY) % NY + NY * ((z + dz + NZ) % NZ));
            p++;
         end
      end
   endfunction

   function automatic int count_bad_pairs();
      int bad = 0;
      for (int i = 0; i < acc_h.size() && i < NP; i++)
         if (acc_h[i] != exp_h[i] || acc_n[i] != exp_n[i]) bad++;
      return bad;
   endfunction

   // Drives one step; rmode 0 ready high, 1 toggled, 2 random. dmode 1 applies the drain pattern.
   task automatic run_step(input int rmode, input bit bank, input int dmode, input int stop_at);
      int cyc = 0;
      int last_acc = -1;
      int t;
      int ph = 0;
      int pn = 0;
      bit r;
      bit prev_stall = 1'b0;
      acc_h.delete();
      acc_n.delete();
      unstable = 0; bank_bad = 0; valid_cycles = 0; done_lat = -1; stall_seen = 0;
      double_buffer = bank;
      phase1_ready  = 1'b1;
      pipe_empty    = (dmode == 0);
      while (cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         if (prev_stall && (pair_valid !== 1'b1 || int'(home_cell) != ph || int'(nbr_cell) != pn)) unstable++;
         if (pair_valid === 1'b1) begin
            valid_cycles++;
            if (read_bank !== bank) bank_bad++;
         end
         if (phase1_done === 1'b1) begin
            done_lat = cyc - last_acc;
            break;
         end
         if (rmode == 0) r = 1'b1;
         else if (rmode == 1) r = (cyc % 2 == 1);
         else r = 1'($urandom_range(0, 1));
         pair_ready = r;
         prev_stall = (pair_valid === 1'b1) && !r;
         if (prev_stall) stall_seen++;
         ph = int'(home_cell);
         pn = int'(nbr_cell);
         if (pair_valid === 1'b1 && r) begin
            acc_h.push_back(int'(home_cell));
            acc_n.push_back(int'(nbr_cell));
            if (acc_h.size() == NP) last_acc = cyc + 1;
            if (acc_h.size() == stop_at) return;
         end
         if (dmode == 1) begin
            if (last_acc < 0) pipe_empty = 1'b0;
            else begin
               t = cyc + 1 - last_acc;
               pipe_empty = !(t <= 20 || t == 26);
            end
         end
      end
   endtask

   task automatic close_step();
      phase1_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; phase1_ready = 1'b0; double_buffer = 1'b0; pair_ready = 1'b0; pipe_empty = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++;
      if (pair_valid !== 1'b0 || home_cell !== 6'd0 || nbr_cell !== 6'd0 || read_bank !== 1'b0 ||
          phase1_done !== 1'b0 || step !== 32'd0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b home=%0d nbr=%0d bank=%b done=%b step=%0d, want all 0",
                  pair_valid, home_cell, nbr_cell, read_bank, phase1_done, step);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (pair_valid !== 1'b0 || phase1_done !== 1'b0) begin
         n_err++;
         $display("FAIL idle_quiet: got valid=%b done=%b, want 0 0", pair_valid, phase1_done);
      end
   endtask

   task automatic test_full_step();
      int bad;
      run_step(0, 1'b0, 0, 0);
      bad = count_bad_pairs();
      n_cmp++;
      if (acc_h.size() != NP || bad != 0) begin
         n_err++;
         $display("FAIL full_pairs: got %0d pairs %0d wrong, want %0d pairs 0 wrong", acc_h.size(), bad, NP);
      end
      n_cmp++;
      if (acc_h.size() < 3 || acc_h[0] != 0 || acc_n[0] != 0 || acc_h[1] != 0 || acc_n[1] != 1 || acc_n[2] != 5) begin
         n_err++;
         $display("FAIL first_pairs: got nbr %0d,%0d,%0d, want 0,1,5", acc_n.size() > 0 ? acc_n[0] : -1,
                  acc_n.size() > 1 ? acc_n[1] : -1, acc_n.size() > 2 ? acc_n[2] : -1);
      end
      n_cmp++;
      if (acc_h.size() != NP || acc_h[NP-1] != 26 || acc_n[NP-1] != 0) begin
         n_err++;
         $display("FAIL wrap_pair: got last home=%0d nbr=%0d, want 26 0",
                  acc_h.size() > 0 ? acc_h[acc_h.size()-1] : -1, acc_n.size() > 0 ? acc_n[acc_n.size()-1] : -1);
      end
      n_cmp++;
      if (valid_cycles != NP) begin
         n_err++;
         $display("FAIL valid_cycles: got %0d, want %0d", valid_cycles, NP);
      end
      n_cmp++;
      if (done_lat != 9) begin
         n_err++;
         $display("FAIL done_latency: got %0d, want 9", done_lat);
      end
      n_cmp++;
      if (step !== 32'd1 || bank_bad != 0) begin
         n_err++;
         $display("FAIL step1: got step=%0d bank_bad=%0d, want 1 0", step, bank_bad);
      end
   endtask

   task automatic test_handshake();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (phase1_done !== 1'b1 || pair_valid !== 1'b0 || step !== 32'd1) begin
            n_err++;
            $display("FAIL done_hold[%0d]: got done=%b valid=%b step=%0d, want 1 0 1", i, phase1_done, pair_valid, step);
         end
      end
      close_step();
      n_cmp++;
      if (phase1_done !== 1'b0 || step !== 32'd1) begin
         n_err++;
         $display("FAIL done_release: got done=%b step=%0d, want 0 1", phase1_done, step);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      run_step(1, 1'b1, 0, 0);
      bad = count_bad_pairs();
      n_cmp++;
      if (acc_h.size() != NP || bad != 0 || unstable != 0) begin
         n_err++;
         $display("FAIL bp_pairs: got %0d pairs %0d wrong %0d unstable, want %0d 0 0", acc_h.size(), bad, unstable, NP);
      end
      n_cmp++;
      if (bank_bad != 0 || step !== 32'd2 || done_lat != 9) begin
         n_err++;
         $display("FAIL bp_step: got bank_bad=%0d step=%0d lat=%0d, want 0 2 9", bank_bad, step, done_lat);
      end
`ifdef PHASE1_SCHED_PERF_EN
      n_cmp++;
      if (stall_cycles !== 32'(stall_seen)) begin
         n_err++;
         $display("FAIL stall_cycles: got %0d, want %0d", stall_cycles, stall_seen);
      end
`endif
      close_step();
   endtask

   task automatic test_drain();
      int bad;
      bit bank = 1'($urandom_range(0, 1));
      run_step(2, bank, 1, 0);
      bad = count_bad_pairs();
      n_cmp++;
      if (acc_h.size() != NP || bad != 0 || unstable != 0 || bank_bad != 0) begin
         n_err++;
         $display("FAIL rand_pairs: got %0d pairs %0d wrong %0d unstable %0d bank_bad, want %0d 0 0 0",
                  acc_h.size(), bad, unstable, bank_bad, NP);
      end
      n_cmp++;
      if (done_lat != 35 || step !== 32'd3) begin
         n_err++;
         $display("FAIL drain_latency: got lat=%0d step=%0d, want 35 3", done_lat, step);
      end
      close_step();
   endtask

   task automatic test_reset_midstep();
      int bad;
      run_step(0, 1'b1, 0, 100);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (pair_valid !== 1'b0 || home_cell !== 6'd0 || nbr_cell !== 6'd0 || read_bank !== 1'b0 ||
          phase1_done !== 1'b0 || step !== 32'd0) begin
         n_err++;
         $display("FAIL async_reset: got valid=%b home=%0d nbr=%0d bank=%b done=%b step=%0d, want all 0",
                  pair_valid, home_cell, nbr_cell, read_bank, phase1_done, step);
      end
      phase1_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_step(0, 1'b0, 0, 0);
      bad = count_bad_pairs();
      n_cmp++;
      if (acc_h.size() != NP || bad != 0 || step !== 32'd1 || done_lat != 9) begin
         n_err++;
         $display("FAIL restart: got %0d pairs %0d wrong step=%0d lat=%0d, want %0d 0 1 9",
                  acc_h.size(), bad, step, done_lat, NP);
      end
      close_step();
   endtask

   initial begin
      build_model();
      test_reset();
      test_full_step();
      test_handshake();
      test_backpressure();
      test_drain();
      test_reset_midstep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
